// File: rtl/robs_control.sv
// Moore controller sequencing a Robertson signed multiplier datapath.
// Drives the 15-bit control word from the state register and steps on the zr/zq status flags.
module robs_control #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        zr,
   input  logic        zq,
   output logic [14:0] c,
   output logic        busy,
   output logic        done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_LOADR,
      S_TEST,
      S_ARITH,
      S_SHIFT,
      S_WB,
      S_STORE,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] iter_q, iter_d;
   logic [14:0]   c_q;
   logic          busy_q, done_q;

   // Control word for a state. add_sel picks add (1) or subtract (0) in ARITH.
   function automatic logic [14:0] decode_c(input state_t s, input logic add_sel);
      logic [14:0] w;
      w = '0;
      case (s)
         S_INIT:  w = 15'h000F;
         S_LOADR: w = 15'h0300;
         S_TEST:  w = 15'h2000;
         S_ARITH: w = 15'h0120 | {4'b0, add_sel, 10'b0};
         S_SHIFT: w = 15'h1800;
         S_WB:    w = 15'h0350;
         S_STORE: w = 15'h4088;
         default: w = '0;
      endcase
      return w;
   endfunction

   always_comb begin
      // NOTE: defaults first so every path assigns every variable; otherwise a latch is inferred.
      state_d = state_q;
      iter_d  = iter_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_INIT;
         S_INIT:  begin
            state_d = S_LOADR;
            iter_d  = '0;
         end
         S_LOADR: state_d = S_TEST;
         S_TEST:  begin
            state_d = zr ? S_SHIFT : S_ARITH;
            iter_d  = iter_q + CW'(1);
         end
         S_ARITH: state_d = S_SHIFT;
         S_SHIFT: state_d = S_WB;
         S_WB:    state_d = zq ? S_STORE : S_TEST;
         S_STORE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // iter mirrors the datapath counter modulo WIDTH: it wraps to zero on the final
   // iteration, giving c10 = ~zq without a combinational path from zq to c.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         c_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         c_q     <= decode_c(state_d, iter_d != '0);
         busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign c    = c_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
